// File: rtl/pq_array_drop.sv
// pq_array_drop: single-cycle sorted-array priority queue of {key, id} cells.
// cell[0] always holds the smallest key; equal keys leave in arrival order.
// Supports push, pop, push+pop, and drop-by-id. When the queue is full, a push
// can either be rejected or evict the tail cell. Key comparison can be plain
// unsigned or serial (wrap-around).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   push_i/push_data_i/push_id_i   insert a cell
//   pop_i                   remove the head cell
//   drop_i/drop_id_i        remove the first cell whose id matches
//   head_data_o/head_id_o   cell[0], driven straight from registers
//   head_valid_o, full_o, count_o   occupancy status
//   drop_hit_o, drop_miss_o, evict_o, err_o   one-cycle event pulses
module pq_array_drop #(
  parameter int DEPTH     = 16,
  parameter int TIME_W    = 24,
  parameter int ID_W      = 24,
  parameter int OVF_EVICT = 0,
  parameter int WRAP_CMP  = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [TIME_W-1:0]          push_data_i,
  input  logic [ID_W-1:0]            push_id_i,
  input  logic                       pop_i,
  input  logic                       drop_i,
  input  logic [ID_W-1:0]            drop_id_i,
  output logic [TIME_W-1:0]          head_data_o,
  output logic [ID_W-1:0]            head_id_o,
  output logic                       head_valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_hit_o,
  output logic                       drop_miss_o,
  output logic                       evict_o,
  output logic                       err_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [TIME_W-1:0] r_key [DEPTH];
  logic [ID_W-1:0]   r_id  [DEPTH];
  logic [CW-1:0]     r_count;
  logic              r_drop_hit, r_drop_miss, r_evict, r_err;

  logic [TIME_W-1:0] w_key_n [DEPTH];
  logic [ID_W-1:0]   w_id_n  [DEPTH];
  logic [CW-1:0]     w_count_n;
  logic              w_drop_hit_n, w_drop_miss_n, w_evict_n, w_err_n;

  // Array shifted down by one (cell[i+1]) and up by one (cell[i-1]).
  logic [TIME_W-1:0] w_dn_key [DEPTH];
  logic [ID_W-1:0]   w_dn_id  [DEPTH];
  logic [TIME_W-1:0] w_up_key [DEPTH];
  logic [ID_W-1:0]   w_up_id  [DEPTH];

  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_le;      // valid cell with key <= new key (a prefix)
  logic [DEPTH-1:0]  w_le_dn;   // w_le of the popped (shifted-down) array
  logic [DEPTH-1:0]  w_le_prv;  // insert point reached at or before i
  logic [DEPTH-1:0]  w_le_sp;   // same, for the popped array
  logic [DEPTH-1:0]  w_match;
  logic [DEPTH-1:0]  w_after;   // at or above the first id match
  logic              w_empty, w_full, w_hit;

  function automatic logic key_lt(input logic [TIME_W-1:0] a, input logic [TIME_W-1:0] b);
    logic [TIME_W-1:0] d;
    d = a - b;
    if (WRAP_CMP != 0) return d[TIME_W-1];
    else               return a < b;
  endfunction

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));

    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = CW'(i) < r_count;
      w_le[i]    = w_valid[i] && !key_lt(push_data_i, r_key[i]);
      w_match[i] = w_valid[i] && (r_id[i] == drop_id_i);
    end

    for (int i = 0; i < DEPTH-1; i++) begin
      w_dn_key[i]  = r_key[i+1];
      w_dn_id[i]   = r_id[i+1];
      w_le_dn[i]   = w_le[i+1];
      w_up_key[i+1] = r_key[i];
      w_up_id[i+1]  = r_id[i];
      w_le_prv[i+1] = w_le[i];
    end
    w_dn_key[DEPTH-1] = '0;
    w_dn_id[DEPTH-1]  = '0;
    w_le_dn[DEPTH-1]  = 1'b0;
    w_up_key[0]       = '0;
    w_up_id[0]        = '0;
    w_le_prv[0]       = 1'b1;

    // In the popped array, entry i-1 is cell[i]; position 0 is always reachable.
    w_le_sp    = w_le;
    w_le_sp[0] = 1'b1;

    w_after[0] = w_match[0];
    for (int i = 1; i < DEPTH; i++) w_after[i] = w_after[i-1] | w_match[i];
    w_hit = |w_match;

    w_key_n       = r_key;
    w_id_n        = r_id;
    w_count_n     = r_count;
    w_drop_hit_n  = 1'b0;
    w_drop_miss_n = 1'b0;
    w_evict_n     = 1'b0;
    w_err_n       = 1'b0;

    if (drop_i && (push_i || pop_i)) begin
      w_err_n = 1'b1;
    end else if (drop_i) begin
      if (w_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          w_key_n[i] = w_after[i] ? w_dn_key[i] : r_key[i];
          w_id_n[i]  = w_after[i] ? w_dn_id[i]  : r_id[i];
        end
        w_count_n    = r_count - 1'b1;
        w_drop_hit_n = 1'b1;
      end else begin
        w_drop_miss_n = 1'b1;
      end
    end else if (push_i && pop_i && !w_empty) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_le_dn[i]) begin
          w_key_n[i] = w_dn_key[i];
          w_id_n[i]  = w_dn_id[i];
        end else if (w_le_sp[i]) begin
          w_key_n[i] = push_data_i;
          w_id_n[i]  = push_id_i;
        end
      end
    end else if (push_i) begin
      // An accompanying pop here means the queue is empty: flag it, still push.
      w_err_n = pop_i;
      // The tail drops off naturally when full, since cell[DEPTH-1] is overwritten.
      if (!w_full || (OVF_EVICT != 0 && !w_le[DEPTH-1])) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!w_le[i]) begin
            w_key_n[i] = w_le_prv[i] ? push_data_i : w_up_key[i];
            w_id_n[i]  = w_le_prv[i] ? push_id_i   : w_up_id[i];
          end
        end
        if (w_full) w_evict_n = 1'b1;
        else        w_count_n = r_count + 1'b1;
      end else begin
        w_err_n = 1'b1;
      end
    end else if (pop_i) begin
      if (w_empty) begin
        w_err_n = 1'b1;
      end else begin
        w_key_n   = w_dn_key;
        w_id_n    = w_dn_id;
        w_count_n = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_key[i] <= '0;
        r_id[i]  <= '0;
      end
      r_count     <= '0;
      r_drop_hit  <= 1'b0;
      r_drop_miss <= 1'b0;
      r_evict     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_key       <= w_key_n;
      r_id        <= w_id_n;
      r_count     <= w_count_n;
      r_drop_hit  <= w_drop_hit_n;
      r_drop_miss <= w_drop_miss_n;
      r_evict     <= w_evict_n;
      r_err       <= w_err_n;
    end
  end

  assign head_data_o  = r_key[0];
  assign head_id_o    = r_id[0];
  assign head_valid_o = (r_count != '0);
  assign full_o       = (r_count == CW'(DEPTH));
  assign count_o      = r_count;
  assign drop_hit_o   = r_drop_hit;
  assign drop_miss_o  = r_drop_miss;
  assign evict_o      = r_evict;
  assign err_o        = r_err;

endmodule

// File: tb/tb_pq_array_drop.sv
// Directed bench for pq_array_drop. Three instances share one stimulus:
// u_rej (reject on overflow), u_evt (evict on overflow), u_wrp (serial compare).
module tb_pq_array_drop;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        push_i, pop_i, drop_i;
  logic [23:0] push_data_i, push_id_i, drop_id_i;

  logic [23:0] r_hd [3];
  logic [23:0] r_hi [3];
  logic [2:0]  hv, fl, dh, dm, ev, er;
  logic [4:0]  cn [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  pq_array_drop #(.OVF_EVICT(0), .WRAP_CMP(0)) u_rej (
    .clk_i, .rst_i, .push_i, .push_data_i, .push_id_i, .pop_i, .drop_i, .drop_id_i,
    .head_data_o(r_hd[0]), .head_id_o(r_hi[0]), .head_valid_o(hv[0]), .full_o(fl[0]),
    .count_o(cn[0]), .drop_hit_o(dh[0]), .drop_miss_o(dm[0]), .evict_o(ev[0]), .err_o(er[0]));

  pq_array_drop #(.OVF_EVICT(1), .WRAP_CMP(0)) u_evt (
    .clk_i, .rst_i, .push_i, .push_data_i, .push_id_i, .pop_i, .drop_i, .drop_id_i,
    .head_data_o(r_hd[1]), .head_id_o(r_hi[1]), .head_valid_o(hv[1]), .full_o(fl[1]),
    .count_o(cn[1]), .drop_hit_o(dh[1]), .drop_miss_o(dm[1]), .evict_o(ev[1]), .err_o(er[1]));

  pq_array_drop #(.OVF_EVICT(0), .WRAP_CMP(1)) u_wrp (
    .clk_i, .rst_i, .push_i, .push_data_i, .push_id_i, .pop_i, .drop_i, .drop_id_i,
    .head_data_o(r_hd[2]), .head_id_o(r_hi[2]), .head_valid_o(hv[2]), .full_o(fl[2]),
    .count_o(cn[2]), .drop_hit_o(dh[2]), .drop_miss_o(dm[2]), .evict_o(ev[2]), .err_o(er[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply one cycle of inputs, then return to idle; outputs are sampled 1 ns later.
  task automatic op(input logic psh, input logic [23:0] d, input logic [23:0] id,
                    input logic pp, input logic drp, input logic [23:0] did);
    push_i = psh; push_data_i = d; push_id_i = id;
    pop_i = pp; drop_i = drp; drop_id_i = did;
    @(posedge clk_i); #1;
    push_i = 1'b0; pop_i = 1'b0; drop_i = 1'b0;
  endtask

  task automatic push(input logic [23:0] d, input logic [23:0] id);
    op(1'b1, d, id, 1'b0, 1'b0, 24'd0);
  endtask

  task automatic pop();
    op(1'b0, 24'd0, 24'd0, 1'b1, 1'b0, 24'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; push_i = 1'b0; pop_i = 1'b0; drop_i = 1'b0;
    push_data_i = '0; push_id_i = '0; drop_id_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    check("rst_count", 32'(cn[0]), 0);
    check("rst_valid", 32'(hv[0]), 0);
    check("rst_full", 32'(fl[0]), 0);
    check("rst_head_data", 32'(r_hd[0]), 0);
    check("rst_head_id", 32'(r_hi[0]), 0);
    check("rst_pulses", 32'({dh[0], dm[0], ev[0], er[0]}), 0);

    push(30, 1); push(10, 2); push(20, 3);
    check("sort_count", 32'(cn[0]), 3);
    check("sort_head_data", 32'(r_hd[0]), 10);
    check("sort_head_id0", 32'(r_hi[0]), 2);
    pop();
    check("sort_head_id1", 32'(r_hi[0]), 3);
    pop();
    check("sort_head_id2", 32'(r_hi[0]), 1);
    pop();
    check("sort_empty", 32'(hv[0]), 0);

    push(5, 7); push(5, 8);
    check("fifo_first", 32'(r_hi[0]), 7);
    pop();
    check("fifo_second", 32'(r_hi[0]), 8);
    pop();
    check("fifo_count", 32'(cn[0]), 0);

    pop();
    check("pop_empty_err", 32'(er[0]), 1);
    check("pop_empty_count", 32'(cn[0]), 0);

    for (int i = 0; i < 16; i++) push(24'(100 + i), 24'(i));
    check("fill_full", 32'(fl[0]), 1);
    check("fill_count", 32'(cn[0]), 16);

    push(50, 99);
    check("rej_err", 32'(er[0]), 1);
    check("rej_count", 32'(cn[0]), 16);
    check("rej_head", 32'(r_hd[0]), 100);
    check("evt_evict", 32'(ev[1]), 1);
    check("evt_err", 32'(er[1]), 0);
    check("evt_head", 32'(r_hd[1]), 50);
    check("evt_count", 32'(cn[1]), 16);

    push(200, 98);
    check("evt_big_err", 32'(er[1]), 1);
    check("evt_big_evict", 32'(ev[1]), 0);

    op(1'b1, 24'd0, 24'd55, 1'b1, 1'b0, 24'd0);
    check("pp_full_count", 32'(cn[0]), 16);
    check("pp_full_head", 32'(r_hd[0]), 0);
    check("pp_full_err", 32'(er[0]), 0);
    check("pp_full_evict", 32'(ev[0]), 0);

    // Tails: u_rej holds 0,101..115 and u_evt holds 0,100..114.
    repeat (15) pop();
    check("rej_tail", 32'(r_hd[0]), 115);
    check("evt_tail", 32'(r_hd[1]), 114);
    check("tail_count", 32'(cn[0]), 1);

    do_reset();
    op(1'b1, 24'd3, 24'd9, 1'b1, 1'b0, 24'd0);
    check("pp_empty_err", 32'(er[0]), 1);
    check("pp_empty_count", 32'(cn[0]), 1);
    check("pp_empty_head", 32'(r_hd[0]), 3);

    do_reset();
    op(1'b0, 24'd0, 24'd0, 1'b0, 1'b1, 24'd4);
    check("drop_empty_miss", 32'(dm[0]), 1);
    push(1, 4); push(2, 5); push(3, 6);
    op(1'b0, 24'd0, 24'd0, 1'b0, 1'b1, 24'd5);
    check("drop_hit", 32'(dh[0]), 1);
    check("drop_hit_miss", 32'(dm[0]), 0);
    check("drop_count", 32'(cn[0]), 2);
    check("drop_head", 32'(r_hi[0]), 4);
    op(1'b0, 24'd0, 24'd0, 1'b0, 1'b1, 24'd9);
    check("drop_miss", 32'(dm[0]), 1);
    check("drop_miss_count", 32'(cn[0]), 2);
    op(1'b0, 24'd0, 24'd0, 1'b1, 1'b1, 24'd4);
    check("drop_pop_err", 32'(er[0]), 1);
    check("drop_pop_count", 32'(cn[0]), 2);
    check("drop_pop_head", 32'(r_hi[0]), 4);
    check("drop_pop_hit", 32'(dh[0]), 0);
    pop();
    check("drop_order", 32'(r_hi[0]), 6);

    do_reset();
    push(24'hFFFFF0, 1); push(24'h000010, 2);
    check("wrap_head", 32'(r_hd[2]), 32'h00FFFFF0);
    check("unsigned_head", 32'(r_hd[0]), 32'h00000010);
    rst_i = 1'b1;
    op(1'b1, 24'd7, 24'd7, 1'b0, 1'b0, 24'd0);
    rst_i = 1'b0;
    check("rst_push_count", 32'(cn[2]), 0);
    check("rst_push_valid", 32'(hv[2]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pq_array_drop.md
Name: pq_array_drop

Overview:
- Parametrised, single-cycle, sorted-array priority queue. Successor to the fixed 16-entry, 24-bit AnTiQ queue.
- Holds {data(time key), id} cells in ascending key order; head is the minimum key.
- New relative to the predecessor: drop-by-id, simultaneous push+pop, selectable overflow policy (reject or evict-tail), and optional wrap-around time comparison.
- Sits between the timer/event producers and the scheduler that consumes the earliest deadline.

Parameters:
- DEPTH, 16, number of cells (>=2).
- TIME_W, 24, width of time key (cell data).
- ID_W, 24, width of cell id.
- OVF_EVICT, 0, 0 = reject push when full; 1 = evict tail cell when new key is strictly smaller than tail key.
- WRAP_CMP, 0, 0 = unsigned compare; 1 = serial compare: a<b iff MSB of (a-b) mod 2^TIME_W is 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- push_i  in  1  insert {push_data_i, push_id_i}
- push_data_i  in  TIME_W  key of new cell
- push_id_i  in  ID_W  id of new cell
- pop_i  in  1  remove head cell
- drop_i  in  1  remove first cell whose id equals drop_id_i
- drop_id_i  in  ID_W  id to drop
- head_data_o  out  TIME_W  key of cell[0]
- head_id_o  out  ID_W  id of cell[0]
- head_valid_o  out  1  queue non-empty
- full_o  out  1  count == DEPTH
- count_o  out  $clog2(DEPTH+1)  occupancy
- drop_hit_o  out  1  pulse: drop removed a cell
- drop_miss_o  out  1  pulse: drop found no match
- evict_o  out  1  pulse: tail cell evicted (OVF_EVICT=1)
- err_o  out  1  pulse: rejected push, pop on empty, or illegal combination

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: count_o=0, head_valid_o=0, full_o=0, all pulses 0. Cell contents are cleared to 0, so head_data_o=0 and head_id_o=0.
- A reset asserted mid-operation wins: any op in that cycle is discarded.
- Storage: register array cell[0..DEPTH-1]. Valid cells occupy indices 0..count-1 in non-decreasing key order.
- Head outputs are driven directly from cell[0] registers, so there is no combinational path from inputs.
- Ordering: a pushed cell is inserted after all existing cells with key <= its key. Equal keys therefore pop in FIFO order.
- Insert position: position = number of valid cells with cell.key <= new key. Computed with a parallel per-cell compare; cells at or above the position shift up by one.
- All operations complete in one cycle. Their effects, and the pulse outputs, are visible the cycle after the clock edge.
- Pulses are high for exactly one cycle.
- Legal op combinations per cycle:
  - push only
  - pop only
  - push+pop
  - drop only
  - Any combination of drop_i with push_i or pop_i: whole cycle ignored, err_o=1.
- Push, not full: insert, count+1.
- Push, full, OVF_EVICT=0: rejected, err_o=1, queue unchanged.
- Push, full, OVF_EVICT=1:
  - If new key < tail key: tail discarded, new cell inserted, evict_o=1, count unchanged.
  - Otherwise: rejected, err_o=1.
- Pop, non-empty: all cells shift down by one, count-1.
- Pop, empty: err_o=1, no change.
- Push+pop, non-empty: head removed and new cell inserted in the same cycle. Count unchanged; this is legal when full, with no eviction or error.
- Push+pop, empty: pop is invalid, err_o=1; the push is still performed and count becomes 1.
- Drop: the lowest-index cell with matching id is removed, higher cells shift down, count-1, drop_hit_o=1.
  - No match: drop_miss_o=1, no change.
  - Drop on empty: drop_miss_o=1.
- WRAP_CMP=1: all key comparisons (insert position, evict test) use the serial compare.
  - The user guarantees that live keys span less than 2^(TIME_W-1).

Test Plan:
- Reset, then push keys 30, 10, 20 (ids 1, 2, 3). Required: count_o=3, head={10,2}. Pops return ids 2, 3, 1, then head_valid_o=0.
- Push key 5 with id 7, then key 5 with id 8, then pop twice. Required: id 7 first, then id 8 (FIFO among equal keys).
- Fill DEPTH=16 with keys 100..115.
  - OVF_EVICT=0, push 50: err_o=1, count stays 16.
  - OVF_EVICT=1, push 50: evict_o=1, head=50, tail=114.
  - OVF_EVICT=1, push 200: err_o=1.
- Queue holds ids 4, 5, 6. drop_id_i=5: drop_hit_o=1, count=2, order 4, 6 kept. drop_id_i=9: drop_miss_o=1. drop_i with pop_i together: err_o=1, queue unchanged.
- Full queue, push+pop with key 0: count stays 16, head=0, err_o=0. Empty queue, push+pop with key 3: err_o=1, count=1, head=3.
- WRAP_CMP=1, TIME_W=24: push 0xFFFFF0 then 0x000010. Required: head=0xFFFFF0. Assert rst_i with a push in the same cycle: count_o=0 next cycle.
